// File: rtl/spi_ctrl_pkg.sv
// spi_ctrl_pkg: register offsets, STATUS bit layout, FSM states and helpers
// shared by the SPI controller CSR block and its FIFOs.
package spi_ctrl_pkg;

    localparam logic [3:0] OFF_CMD       = 4'd0;
    localparam logic [3:0] OFF_ADDR      = 4'd1;
    localparam logic [3:0] OFF_ADDR_CFG  = 4'd2;
    localparam logic [3:0] OFF_DUMMY_CFG = 4'd3;
    localparam logic [3:0] OFF_DATA_CFG  = 4'd4;
    localparam logic [3:0] OFF_CS_SEL    = 4'd5;
    localparam logic [3:0] OFF_TXFIFO    = 4'd6;
    localparam logic [3:0] OFF_RXFIFO    = 4'd7;
    localparam logic [3:0] OFF_STATUS    = 4'd8;
    localparam logic [3:0] OFF_IRQ_EN    = 4'd9;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_CMD_ERR  = 2;
    localparam int STAT_TX_OVF   = 3;
    localparam int STAT_RX_OVF   = 4;
    localparam int STAT_RX_UNF   = 5;
    localparam int STAT_TX_FLUSH = 8;
    localparam int STAT_RX_FLUSH = 9;
    localparam int STAT_RX_LVL   = 16;
    localparam int STAT_TX_LVL   = 24;

    localparam logic [31:0] DEFAULT_RDATA  = 32'hDEADBEEF;
    localparam logic [2:0]  MAX_ADDR_BYTES = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_BUSY
    } state_t;

    function automatic logic [2:0] sat_addr_bytes(input logic [2:0] value);
        return (value > MAX_ADDR_BYTES) ? MAX_ADDR_BYTES : value;
    endfunction

endpackage

// File: rtl/spi_ctrl_fifo.sv
// spi_ctrl_fifo: 8-bit synchronous FIFO with level output and synchronous flush.
// A pop frees the slot in the same cycle, so push+pop on a full FIFO both succeed.
module spi_ctrl_fifo
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [7:0]               head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? 8'h00 : mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Flush outranks any push or pop issued in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/spi_ctrl_csr.sv
// spi_ctrl_csr: CPU register front-end that issues transfer requests to an SPI engine.
// Define SPI_CTRL_IRQ_EN to build the IRQ_EN register and drive the irq output.
module spi_ctrl_csr
    import spi_ctrl_pkg::*;
#(
    parameter int NUM_CS     = 4,
    parameter int FIFO_DEPTH = 16,
    localparam int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_if_read,
    input  logic              cpu_if_write,
    input  logic [31:2]       cpu_if_address,
    input  logic [31:0]       cpu_if_write_data,
    output logic [31:0]       cpu_if_read_data,
    output logic              cpu_if_access_complete,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [7:0]        command,
    output logic              read_write_n,
    output logic [31:0]       address,
    output logic [2:0]        address_bytes,
    output logic [3:0]        dummy_cycles,
    output logic [7:0]        data_bytes,
    output logic [CS_W-1:0]   chip_select,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              access_complete,
    output logic              irq
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    state_t          state;
    state_t          state_next;
    logic [3:0]      offset;
    logic            is_idle;
    logic            cmd_wr;
    logic            start;
    logic            status_wr;
    logic            txfifo_wr;
    logic            rxfifo_rd;
    logic            tx_pop;
    logic            tx_flush;
    logic            rx_flush;
    logic            unused_addr_bits;

    logic [8:0]      cmd_reg;
    logic [31:0]     addr_reg;
    logic [2:0]      addr_cfg;
    logic [3:0]      dummy_cfg;
    logic [7:0]      data_cfg;
    logic [CS_W-1:0] cs_sel;
    logic [5:1]      sticky;
    logic [5:1]      sticky_set;
    logic [5:1]      sticky_clr;
    logic [31:0]     status_word;
    logic [31:0]     irq_en_word;
    logic [31:0]     rd_mux;

    logic [7:0]      tx_head;
    logic            tx_empty;
    logic            tx_full;
    logic [LVL_W-1:0] tx_level;
    logic [7:0]      rx_head;
    logic            rx_empty;
    logic            rx_full;
    logic [LVL_W-1:0] rx_level;

    assign offset           = cpu_if_address[5:2];
    assign unused_addr_bits = ^cpu_if_address[31:6];
    assign is_idle          = (state == ST_IDLE);
    assign cmd_wr           = cpu_if_write && (offset == OFF_CMD);
    assign start            = cmd_wr && is_idle;
    assign status_wr        = cpu_if_write && (offset == OFF_STATUS);
    assign txfifo_wr        = cpu_if_write && (offset == OFF_TXFIFO);
    assign rxfifo_rd        = cpu_if_read && (offset == OFF_RXFIFO);
    assign tx_flush         = status_wr && cpu_if_write_data[STAT_TX_FLUSH];
    assign rx_flush         = status_wr && cpu_if_write_data[STAT_RX_FLUSH];
    assign tx_valid         = !tx_empty;
    assign tx_data          = tx_head;
    assign tx_pop           = tx_valid && tx_ready;

    spi_ctrl_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (txfifo_wr),
        .push_data (cpu_if_write_data[7:0]),
        .pop       (tx_pop),
        .flush     (tx_flush),
        .head      (tx_head),
        .empty     (tx_empty),
        .full      (tx_full),
        .level     (tx_level)
    );

    spi_ctrl_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (rx_valid),
        .push_data (rx_data),
        .pop       (rxfifo_rd),
        .flush     (rx_flush),
        .head      (rx_head),
        .empty     (rx_empty),
        .full      (rx_full),
        .level     (rx_level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                req_valid = 1'b1;
                if (req_ready) begin
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (access_complete) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A dropped push only counts as overflow when no pop freed a slot and no flush discarded it.
    always_comb begin
        sticky_set               = '0;
        sticky_set[STAT_DONE]    = (state == ST_BUSY) && access_complete;
        sticky_set[STAT_CMD_ERR] = cmd_wr && !is_idle;
        sticky_set[STAT_TX_OVF]  = txfifo_wr && tx_full && !tx_pop;
        sticky_set[STAT_RX_OVF]  = rx_valid && rx_full && !rxfifo_rd && !rx_flush;
        sticky_set[STAT_RX_UNF]  = rxfifo_rd && rx_empty;
        sticky_clr               = status_wr ? cpu_if_write_data[5:1] : '0;
    end

    always_comb begin
        status_word                         = '0;
        status_word[STAT_BUSY]              = !is_idle;
        status_word[5:1]                    = sticky;
        status_word[STAT_RX_LVL +: 8]       = 8'(rx_level);
        status_word[STAT_TX_LVL +: 8]       = 8'(tx_level);
    end

    always_comb begin
        rd_mux = DEFAULT_RDATA;
        case (offset)
            OFF_CMD:       rd_mux = {23'd0, cmd_reg};
            OFF_ADDR:      rd_mux = addr_reg;
            OFF_ADDR_CFG:  rd_mux = {29'd0, addr_cfg};
            OFF_DUMMY_CFG: rd_mux = {28'd0, dummy_cfg};
            OFF_DATA_CFG:  rd_mux = {24'd0, data_cfg};
            OFF_CS_SEL:    rd_mux = 32'(cs_sel);
            OFF_TXFIFO:    rd_mux = 32'd0;
            OFF_RXFIFO:    rd_mux = {24'd0, rx_head};
            OFF_STATUS:    rd_mux = status_word;
            OFF_IRQ_EN:    rd_mux = irq_en_word;
            default:       rd_mux = DEFAULT_RDATA;
        endcase
    end

    // Configuration registers only move while idle; the request outputs are a snapshot taken on CMD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_reg       <= '0;
            addr_reg      <= '0;
            addr_cfg      <= '0;
            dummy_cfg     <= '0;
            data_cfg      <= '0;
            cs_sel        <= '0;
            command       <= '0;
            read_write_n  <= 1'b0;
            address       <= '0;
            address_bytes <= '0;
            dummy_cycles  <= '0;
            data_bytes    <= '0;
            chip_select   <= '0;
        end else begin
            if (cpu_if_write && is_idle) begin
                case (offset)
                    OFF_CMD:       cmd_reg   <= cpu_if_write_data[8:0];
                    OFF_ADDR:      addr_reg  <= cpu_if_write_data;
                    OFF_ADDR_CFG:  addr_cfg  <= sat_addr_bytes(cpu_if_write_data[2:0]);
                    OFF_DUMMY_CFG: dummy_cfg <= cpu_if_write_data[3:0];
                    OFF_DATA_CFG:  data_cfg  <= cpu_if_write_data[7:0];
                    OFF_CS_SEL:    cs_sel    <= cpu_if_write_data[CS_W-1:0];
                    default: ;
                endcase
            end
            if (start) begin
                command       <= cpu_if_write_data[7:0];
                read_write_n  <= cpu_if_write_data[8];
                address       <= addr_reg;
                address_bytes <= addr_cfg;
                dummy_cycles  <= dummy_cfg;
                data_bytes    <= data_cfg;
                chip_select   <= cs_sel;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky                 <= '0;
            cpu_if_access_complete <= 1'b0;
            cpu_if_read_data       <= '0;
        end else begin
            sticky                 <= (sticky & ~sticky_clr) | sticky_set;
            cpu_if_access_complete <= cpu_if_read || cpu_if_write;
            cpu_if_read_data       <= cpu_if_read ? rd_mux : 32'd0;
        end
    end

`ifdef SPI_CTRL_IRQ_EN
    logic [5:1] irq_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en <= '0;
        end else if (cpu_if_write && (offset == OFF_IRQ_EN)) begin
            irq_en <= cpu_if_write_data[5:1];
        end
    end

    assign irq_en_word = {26'd0, irq_en, 1'b0};
    assign irq         = |(sticky & irq_en);
`else
    assign irq_en_word = 32'd0;
    assign irq         = 1'b0;
`endif

endmodule

// File: doc/spi_ctrl_csr.md
SPI_CTRL_CSR -- requirements
Module: spi_ctrl_csr

Interface
REQ-001 NUM_CS, 4, number of chip selects, legal 1..8; CS_W = max(1, clog2(NUM_CS)).
REQ-002 FIFO_DEPTH, 16, entries per TX and RX FIFO, power of 2, legal 4..64.
REQ-003 clk  input  1  sole clock, all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous assert, active-low reset; deassertion synchronous to clk.
REQ-005 cpu_if_read / cpu_if_write  input  1 each  single-cycle CPU access strobes, never both high.
REQ-006 cpu_if_address  input  [31:2]  word address; only bits [5:2] decoded.
REQ-007 cpu_if_write_data  input  32  write data.
REQ-008 cpu_if_read_data  output  32  read data, valid with cpu_if_access_complete.
REQ-009 cpu_if_access_complete  output  1  one-cycle pulse one cycle after any strobe.
REQ-010 req_valid / req_ready  output / input  1 each  transfer request handshake to SPI engine.
REQ-011 command  output  8  opcode; read_write_n  output  1  1 = read transfer.
REQ-012 address  output  32; address_bytes  output  3  count 0..4, 0 = no address phase.
REQ-013 dummy_cycles  output  4, 0 = none; data_bytes  output  8, 0 = no data phase.
REQ-014 chip_select  output  CS_W  selected device index.
REQ-015 tx_data  output  8; tx_valid  output  1; tx_ready  input  1  TX FIFO pop handshake.
REQ-016 rx_data  input  8; rx_valid  input  1  RX FIFO push, no backpressure.
REQ-017 access_complete  input  1  one-cycle pulse, engine finished transfer.
REQ-018 irq  output  1  level interrupt.

Function
REQ-019 Register map (word offset): 0 CMD [7:0] command,[8] read_write_n; 1 ADDR; 2 ADDR_CFG [2:0]; 3 DUMMY_CFG [3:0]; 4 DATA_CFG [7:0]; 5 CS_SEL [CS_W-1:0]; 6 TXFIFO [7:0]; 7 RXFIFO [7:0]; 8 STATUS; 9 IRQ_EN; others read 32'hDEADBEEF, writes ignored.
REQ-020 STATUS bits: [0] busy RO, [1] done, [2] cmd_err, [3] tx_ovf, [4] rx_ovf, [5] rx_unf (sticky, write-1-clear), [8] tx_flush, [9] rx_flush (write-1 self-clearing), [23:16] rx level, [31:24] tx level.
REQ-021 FSM IDLE->REQ on CMD write while IDLE; REQ holds req_valid=1 and all request outputs stable until req_ready=1; REQ->BUSY on handshake; BUSY->IDLE on access_complete, setting done.
REQ-022 CMD write while not IDLE is ignored and sets cmd_err; ADDR/ADDR_CFG/DUMMY_CFG/DATA_CFG/CS_SEL writes while not IDLE are ignored.
REQ-023 Request outputs are shadow copies latched on the CMD write; CSR reads return the written registers.
REQ-024 TXFIFO write pushes [7:0]; push when full dropped, sets tx_ovf; tx_valid = not empty, pop on tx_valid & tx_ready.
REQ-025 RXFIFO read returns head in [7:0] and pops; read when empty returns 0 and sets rx_unf; rx_valid when full drops byte, sets rx_ovf; simultaneous pop and push when full both succeed.
REQ-026 Flush empties the addressed FIFO the cycle after the write and takes priority over a same-cycle push.
REQ-027 Sticky set and W1C on same cycle: set wins.
REQ-028 ADDR_CFG values 5..7 written saturate to 4.

Reset
REQ-029 reset_n low: FSM IDLE, FIFOs empty, all outputs and registers 0, including mid-transfer; a pending access_complete is discarded.

Configuration
REQ-030 SPI_CTRL_IRQ_EN defined: irq = |(STATUS[5:1] & IRQ_EN[5:1]); undefined: irq tied 0, IRQ_EN reads 0 and writes are ignored.

Structure
REQ-031 Package spi_ctrl_pkg holds register offsets, STATUS bit positions, FSM state enum, the 32'hDEADBEEF default read value.
REQ-032 Sub-module spi_ctrl_fifo (sync FIFO, parameter DEPTH, width 8, level output) instantiated for TX and RX.

Verification
REQ-033 Program ADDR=0x00123456, ADDR_CFG=3, CMD=0x103 -> req_valid=1 with command 0x03, read_write_n=1, address_bytes=3; held 5 cycles until req_ready; busy=1 until access_complete, then done=1.
REQ-034 CMD write during BUSY -> no second request, cmd_err=1; write STATUS 0x4 -> cmd_err=0.
REQ-035 Push FIFO_DEPTH+1 bytes to TXFIFO -> tx level=FIFO_DEPTH, tx_ovf=1; tx_ready held -> bytes popped in order.
REQ-036 RXFIFO read when empty -> data 0, rx_unf=1; full RX with same-cycle pop and push -> level unchanged, no rx_ovf.
REQ-037 reset_n pulsed low in BUSY -> req_valid=0, busy=0, FIFO levels 0; later access_complete ignored.
REQ-038 With SPI_CTRL_IRQ_EN: IRQ_EN=0x2, transfer completes -> irq=1; W1C done -> irq=0; without macro irq stays 0.
